// File: rtl/fp_pkg.sv
// Shared single-precision constants, rounding-mode encoding and small
// helpers for the FPU datapaths (divider, multiplier).
package fp_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned MANT_W = FRAC_W + 1;
   localparam int unsigned WORD_W = EXP_W + FRAC_W + 1;
   // Quotient bits: 1 integer, 23 fraction, guard, extra.
   localparam int unsigned QBITS  = 26;
   localparam int unsigned BIAS   = 127;

   localparam logic [31:0] QNAN       = 32'h7fc00000;
   localparam logic [31:0] POS_INF    = 32'h7f800000;
   localparam logic [31:0] MAX_FINITE = 32'h7f7fffff;

   // Encodings 101..111 are not listed and fall back to round-to-nearest-even.
   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } rmode_t;

   function automatic logic [31:0] signed_inf(input logic sign);
      return {sign, POS_INF[30:0]};
   endfunction

   function automatic logic [31:0] signed_max(input logic sign);
      return {sign, MAX_FINITE[30:0]};
   endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Start/done handshake and result bus between the execute stage and the
// sequential divider.
interface fp_div_seq_if;
   import fp_pkg::*;

   logic              start;
   logic [WORD_W-1:0] fp_X;
   logic [WORD_W-1:0] fp_Y;
   logic [2:0]        r_mode;
   logic              busy;
   logic              done;
   logic [WORD_W-1:0] fp_Z;
   logic              ovrf;
   logic              udrf;
   logic              dz;
   logic              nan;

   modport master (
      output start, fp_X, fp_Y, r_mode,
      input  busy, done, fp_Z, ovrf, udrf, dz, nan
   );

   modport slave (
      input  start, fp_X, fp_Y, r_mode,
      output busy, done, fp_Z, ovrf, udrf, dz, nan
   );

endinterface

// File: rtl/fp_round.sv
// Combinational rounding of a normalized 23-bit fraction given guard and
// sticky; a carry out means the significand wrapped to 1.0 x 2^(E+1).
module fp_round
   import fp_pkg::*;
(
   input  logic [FRAC_W-1:0] mant,
   input  logic              guard,
   input  logic              sticky,
   input  logic              sign,
   input  logic [2:0]        r_mode,
   output logic [FRAC_W-1:0] mant_rnd,
   output logic              carry
);

   logic inc;

   // Decide whether the discarded bits push the result up by one ulp.
   always_comb begin
      inc = 1'b0;
      case (r_mode)
         RM_RTZ:  inc = 1'b0;
         RM_RDN:  inc = sign & (guard | sticky);
         RM_RUP:  inc = ~sign & (guard | sticky);
         RM_RMM:  inc = guard;
         default: inc = guard & (sticky | mant[0]);
      endcase
   end

   assign {carry, mant_rnd} = {1'b0, mant} + {{FRAC_W{1'b0}}, inc};

endmodule

// File: rtl/fp_div_seq.sv
// Iterative single-precision divider: special-case screening, one restoring
// quotient bit per cycle, then normalize/round/range-check in one cycle.
module fp_div_seq
   import fp_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   fp_div_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SPECIAL = 3'd1,
      S_DIV     = 3'd2,
      S_ROUND   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              state;
   logic [4:0]          cnt;
   logic [WORD_W-1:0]   x_r, y_r;
   logic [2:0]          rm_r;
   logic [MANT_W:0]     rem;
   logic [QBITS-1:0]    q;
   logic [WORD_W-1:0]   z_r;
   logic                ovrf_r, udrf_r, dz_r, nan_r;

   // Operand field decode (exponent 0 is flushed to signed zero).
   logic [EXP_W-1:0]  x_exp, y_exp;
   logic              sign;
   logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
   logic [MANT_W-1:0] my;

   assign x_exp  = x_r[WORD_W-2 -: EXP_W];
   assign y_exp  = y_r[WORD_W-2 -: EXP_W];
   assign sign   = x_r[WORD_W-1] ^ y_r[WORD_W-1];
   assign x_zero = (x_exp == '0);
   assign y_zero = (y_exp == '0);
   assign x_inf  = (x_exp == '1) && (x_r[FRAC_W-1:0] == '0);
   assign y_inf  = (y_exp == '1) && (y_r[FRAC_W-1:0] == '0);
   assign x_nan  = (x_exp == '1) && (x_r[FRAC_W-1:0] != '0);
   assign y_nan  = (y_exp == '1) && (y_r[FRAC_W-1:0] != '0);
   assign my     = {1'b1, y_r[FRAC_W-1:0]};

   logic              spec_hit, spec_dz, spec_nan;
   logic [WORD_W-1:0] spec_z;

   // Resolve special operand combinations in priority order.
   always_comb begin
      spec_hit = 1'b1;
      spec_dz  = 1'b0;
      spec_nan = 1'b0;
      spec_z   = '0;
      if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
         spec_z   = QNAN;
         spec_nan = 1'b1;
      end else if (x_inf) begin
         spec_z = signed_inf(sign);
      end else if (y_inf) begin
         spec_z = {sign, {(WORD_W-1){1'b0}}};
      end else if (y_zero) begin
         spec_z  = signed_inf(sign);
         spec_dz = 1'b1;
      end else if (x_zero) begin
         spec_z = {sign, {(WORD_W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Restoring step: trial subtract of the divisor from the partial remainder.
   logic            rem_ge;
   logic [MANT_W:0] rem_sub, rem_nx;

   assign rem_ge  = (rem >= {1'b0, my});
   assign rem_sub = rem - {1'b0, my};
   assign rem_nx  = rem_ge ? rem_sub : rem;

   // Normalization: q[25] is the integer bit; when clear, the quotient is in
   // [0.5,1) and everything shifts down one place with the exponent.
   logic              q_int;
   logic [FRAC_W-1:0] mant, mant_rnd;
   logic              guard, sticky, carry;
   logic signed [9:0] e_pre, e_rnd;

   assign q_int  = q[QBITS-1];
   assign mant   = q_int ? q[QBITS-2:2] : q[QBITS-3:1];
   assign guard  = q_int ? q[1] : q[0];
   assign sticky = (q_int & q[0]) | (rem != '0);
   assign e_pre  = {2'b00, x_exp} - {2'b00, y_exp} + 10'(BIAS) - {9'd0, ~q_int};
   assign e_rnd  = e_pre + {9'd0, carry};

   fp_round u_round (
      .mant     (mant),
      .guard    (guard),
      .sticky   (sticky),
      .sign     (sign),
      .r_mode   (rm_r),
      .mant_rnd (mant_rnd),
      .carry    (carry)
   );

   logic [WORD_W-1:0] rnd_z;
   logic              rnd_ovrf, rnd_udrf;

   // Range-check the rounded result; overflow saturates per rounding direction.
   always_comb begin
      rnd_ovrf = 1'b0;
      rnd_udrf = 1'b0;
      rnd_z    = {sign, e_rnd[EXP_W-1:0], mant_rnd};
      if (e_rnd >= 10'sd255) begin
         rnd_ovrf = 1'b1;
         case (rm_r)
            RM_RTZ:  rnd_z = signed_max(sign);
            RM_RDN:  rnd_z = sign ? signed_inf(sign) : signed_max(sign);
            RM_RUP:  rnd_z = sign ? signed_max(sign) : signed_inf(sign);
            default: rnd_z = signed_inf(sign);
         endcase
      end else if (e_rnd <= 10'sd0) begin
         rnd_udrf = 1'b1;
         rnd_z    = {sign, {(WORD_W-1){1'b0}}};
      end
   end

   // Control FSM plus operand, quotient and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         x_r    <= '0;
         y_r    <= '0;
         rm_r   <= '0;
         rem    <= '0;
         q      <= '0;
         z_r    <= '0;
         ovrf_r <= 1'b0;
         udrf_r <= 1'b0;
         dz_r   <= 1'b0;
         nan_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x_r    <= bus.fp_X;
                  y_r    <= bus.fp_Y;
                  rm_r   <= bus.r_mode;
                  ovrf_r <= 1'b0;
                  udrf_r <= 1'b0;
                  dz_r   <= 1'b0;
                  nan_r  <= 1'b0;
                  state  <= S_SPECIAL;
               end
            end
            S_SPECIAL: begin
               if (spec_hit) begin
                  z_r   <= spec_z;
                  dz_r  <= spec_dz;
                  nan_r <= spec_nan;
                  state <= S_DONE;
               end else begin
                  rem   <= {2'b01, x_r[FRAC_W-1:0]};
                  q     <= '0;
                  cnt   <= '0;
                  state <= S_DIV;
               end
            end
            S_DIV: begin
               q   <= {q[QBITS-2:0], rem_ge};
               rem <= {rem_nx[MANT_W-1:0], 1'b0};
               cnt <= cnt + 5'd1;
               if (cnt == 5'(QBITS - 1)) begin
                  state <= S_ROUND;
               end
            end
            S_ROUND: begin
               z_r    <= rnd_z;
               ovrf_r <= rnd_ovrf;
               udrf_r <= rnd_udrf;
               state  <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = (state == S_DONE);
   assign bus.fp_Z = z_r;
   assign bus.ovrf = ovrf_r;
   assign bus.udrf = udrf_r;
   assign bus.dz   = dz_r;
   assign bus.nan  = nan_r;

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, randomized operands
// against an arithmetic reference model, and handshake corner cases.
module tb_fp_div_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   fp_div_seq_if bus ();

   fp_div_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference: returns {special, ovrf, udrf, dz, nan, fp_Z}. The quotient is
   // formed by scaled integer division; rounding decisions come from comparing
   // twice the remainder with the divisor.
   function automatic logic [36:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                           input logic [2:0] rm);
      logic s, inc, xz, xi, xn, yz, yi, yn;
      int   ex, ey, e;
      longint unsigned mx, my, num, sig, r;
      logic [31:0] inf_z, max_z, zero_z, z;
      s      = x[31] ^ y[31];
      ex     = int'(x[30:23]);
      ey     = int'(y[30:23]);
      inf_z  = {s, 8'hff, 23'd0};
      max_z  = {s, 8'hfe, 23'h7fffff};
      zero_z = {s, 31'd0};
      xz = (ex == 0);
      yz = (ey == 0);
      xi = (ex == 255) && (x[22:0] == 23'd0);
      yi = (ey == 255) && (y[22:0] == 23'd0);
      xn = (ex == 255) && (x[22:0] != 23'd0);
      yn = (ey == 255) && (y[22:0] != 23'd0);
      if (xn || yn || (xz && yz) || (xi && yi)) return {1'b1, 4'b0001, 32'h7fc00000};
      if (xi) return {1'b1, 4'b0000, inf_z};
      if (yi) return {1'b1, 4'b0000, zero_z};
      if (yz) return {1'b1, 4'b0010, inf_z};
      if (xz) return {1'b1, 4'b0000, zero_z};
      mx = {40'd0, 1'b1, x[22:0]};
      my = {40'd0, 1'b1, y[22:0]};
      if (mx >= my) begin
         num = mx << 23;
         e   = ex - ey + 127;
      end else begin
         num = mx << 24;
         e   = ex - ey + 126;
      end
      sig = num / my;
      r   = num % my;
      case (rm)
         3'd1:    inc = 1'b0;
         3'd2:    inc = s && (r != 0);
         3'd3:    inc = !s && (r != 0);
         3'd4:    inc = (2 * r >= my);
         default: inc = (2 * r > my) || ((2 * r == my) && sig[0]);
      endcase
      sig = sig + (inc ? 64'd1 : 64'd0);
      if (sig == (64'd1 << 24)) begin
         sig = 64'd1 << 23;
         e   = e + 1;
      end
      if (e >= 255) begin
         case (rm)
            3'd1:    z = max_z;
            3'd2:    z = s ? inf_z : max_z;
            3'd3:    z = s ? max_z : inf_z;
            default: z = inf_z;
         endcase
         return {1'b0, 4'b1000, z};
      end
      if (e <= 0) return {1'b0, 4'b0100, zero_z};
      return {1'b0, 4'b0000, s, 8'(e), sig[22:0]};
   endfunction

   // Issue one operation starting in the next cycle and wait (bounded) for
   // done. lat is the cycle index of done relative to the start cycle, or -1.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                         output logic [31:0] z, output logic [3:0] fl, output int lat);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.fp_X   = x;
      bus.fp_Y   = y;
      bus.r_mode = rm;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.fp_X   = $urandom;
      bus.fp_Y   = $urandom;
      bus.r_mode = 3'($urandom_range(0, 7));
      lat = 1;
      while (bus.done !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (bus.done !== 1'b1) lat = -1;
      z  = bus.fp_Z;
      fl = {bus.ovrf, bus.udrf, bus.dz, bus.nan};
   endtask

   function automatic logic [31:0] rand_operand();
      logic [7:0] e;
      int unsigned k;
      k = $urandom_range(0, 9);
      case (k)
         0:       e = 8'd0;
         1:       e = 8'd255;
         2, 3:    e = 8'($urandom_range(1, 254));
         default: e = 8'($urandom_range(100, 154));
      endcase
      if (k == 1 && $urandom_range(0, 1) == 0) return {1'($urandom), e, 23'd0};
      return {1'($urandom), e, 23'($urandom)};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if ({bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf, bus.dz, bus.nan} !== 38'd0)
         $display("FAIL reset_outputs: got busy=%b done=%b z=%h fl=%b%b%b%b required all 0",
                  bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf, bus.dz, bus.nan);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL reset_idle: got busy=%b done=%b required 0 0", bus.busy, bus.done);
      else n_pass++;
   endtask

   task automatic test_exact();
      logic [31:0] z; logic [3:0] fl; int lat;
      run_op(32'h40c00000, 32'h40400000, 3'd0, z, fl, lat);
      n_total++;
      if (lat !== 29) $display("FAIL exact_latency: got %0d required 29", lat); else n_pass++;
      n_total++;
      if (bus.busy !== 1'b1) $display("FAIL exact_busy_done: got %b required 1", bus.busy); else n_pass++;
      n_total++;
      if (z !== 32'h40000000 || fl !== 4'b0000)
         $display("FAIL exact_result: got %h/%b required 40000000/0000", z, fl);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL exact_after: got busy=%b done=%b required 0 0", bus.busy, bus.done);
      else n_pass++;
   endtask

   task automatic test_one_third();
      logic [31:0] z; logic [3:0] fl; int lat;
      logic [31:0] req [5];
      req = '{32'h3eaaaaab, 32'h3eaaaaaa, 32'h3eaaaaaa, 32'h3eaaaaab, 32'h3eaaaaab};
      for (int m = 0; m < 5; m++) begin
         run_op(32'h3f800000, 32'h40400000, 3'(m), z, fl, lat);
         n_total++;
         if (z !== req[m] || fl !== 4'b0000 || lat !== 29)
            $display("FAIL third_mode%0d: got %h/%b lat %0d required %h/0000 lat 29",
                     m, z, fl, lat, req[m]);
         else n_pass++;
      end
   endtask

   task automatic test_specials();
      logic [31:0] z; logic [3:0] fl; int lat;
      logic [67:0] tbl [4];
      tbl = '{{32'h3f800000, 32'h00000000, 4'b0010},
              {32'h00000000, 32'h00000000, 4'b0001},
              {32'h7f800000, 32'hc0000000, 4'b0000},
              {32'h3f800000, 32'h7f800000, 4'b0000}};
      for (int i = 0; i < 4; i++) begin
         logic [31:0] req_z;
         case (i)
            0:       req_z = 32'h7f800000;
            1:       req_z = 32'h7fc00000;
            2:       req_z = 32'hff800000;
            default: req_z = 32'h00000000;
         endcase
         run_op(tbl[i][67:36], tbl[i][35:4], 3'd0, z, fl, lat);
         n_total++;
         if (z !== req_z || fl !== tbl[i][3:0] || lat !== 2)
            $display("FAIL special_%0d: got %h/%b lat %0d required %h/%b lat 2",
                     i, z, fl, lat, req_z, tbl[i][3:0]);
         else n_pass++;
      end
   endtask

   task automatic test_range();
      logic [31:0] z; logic [3:0] fl; int lat;
      run_op(32'h7f000000, 32'h3e800000, 3'd0, z, fl, lat);
      n_total++;
      if (z !== 32'h7f800000 || fl !== 4'b1000)
         $display("FAIL ovf_rne: got %h/%b required 7f800000/1000", z, fl);
      else n_pass++;
      run_op(32'h7f000000, 32'h3e800000, 3'd1, z, fl, lat);
      n_total++;
      if (z !== 32'h7f7fffff || fl !== 4'b1000)
         $display("FAIL ovf_rtz: got %h/%b required 7f7fffff/1000", z, fl);
      else n_pass++;
      run_op(32'h00800000, 32'h40000000, 3'd0, z, fl, lat);
      n_total++;
      if (z !== 32'h00000000 || fl !== 4'b0100 || lat !== 29)
         $display("FAIL udf: got %h/%b lat %0d required 00000000/0100 lat 29", z, fl, lat);
      else n_pass++;
      run_op(32'h80400000, 32'h3f800000, 3'd0, z, fl, lat);
      n_total++;
      if (z !== 32'h80000000 || fl !== 4'b0000 || lat !== 2)
         $display("FAIL flush_sub: got %h/%b lat %0d required 80000000/0000 lat 2", z, fl, lat);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] x, y, z; logic [3:0] fl; logic [2:0] rm; logic [36:0] r; int lat;
      for (int i = 0; i < 80; i++) begin
         x  = rand_operand();
         y  = rand_operand();
         rm = 3'($urandom_range(0, 7));
         r  = ref_div(x, y, rm);
         run_op(x, y, rm, z, fl, lat);
         n_total++;
         if (z !== r[31:0] || fl !== r[35:32] || lat !== (r[36] ? 2 : 29))
            $display("FAIL random_%0d: %h/%h rm=%0d got %h/%b lat %0d required %h/%b lat %0d",
                     i, x, y, rm, z, fl, lat, r[31:0], r[35:32], r[36] ? 2 : 29);
         else n_pass++;
      end
   endtask

   task automatic test_ignored_start();
      int dones = 0;
      int busy_after = 0;
      logic [31:0] z29 = '0;
      logic [3:0]  fl29 = '1;
      logic        done29 = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.fp_X = 32'h3f800000; bus.fp_Y = 32'h40400000; bus.r_mode = 3'd0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.done === 1'b1) dones++;
         if (c == 5 || c == 29) begin
            bus.start = 1'b1; bus.fp_X = 32'h7f000000; bus.fp_Y = 32'h3e800000; bus.r_mode = 3'd1;
         end
         if (c == 29) begin
            done29 = bus.done;
            z29    = bus.fp_Z;
            fl29   = {bus.ovrf, bus.udrf, bus.dz, bus.nan};
         end
         if (c >= 30 && bus.busy !== 1'b0) busy_after++;
      end
      n_total++;
      if (done29 !== 1'b1 || z29 !== 32'h3eaaaaab || fl29 !== 4'b0000)
         $display("FAIL ignore_result: got done=%b %h/%b required 1 3eaaaaab/0000", done29, z29, fl29);
      else n_pass++;
      n_total++;
      if (dones !== 1 || busy_after !== 0)
         $display("FAIL ignore_extra: got dones=%0d busy_cycles=%0d required 1 0", dones, busy_after);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      int busy_cycles = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.fp_X = 32'h40c00000; bus.fp_Y = 32'h40400000; bus.r_mode = 3'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_total++;
      if ({bus.busy, bus.done, bus.fp_Z, bus.ovrf, bus.udrf, bus.dz, bus.nan} !== 38'd0)
         $display("FAIL midreset_outputs: got busy=%b done=%b z=%h required all 0",
                  bus.busy, bus.done, bus.fp_Z);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) dones++;
         if (bus.busy === 1'b1) busy_cycles++;
      end
      n_total++;
      if (dones !== 0 || busy_cycles !== 0)
         $display("FAIL midreset_quiet: got dones=%0d busy_cycles=%0d required 0 0", dones, busy_cycles);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] z; logic [3:0] fl; int lat;
      logic [31:0] xs [3];
      logic [31:0] ys [3];
      logic [36:0] r;
      xs = '{32'hc1200000, 32'h3f800000, 32'h42f60000};
      ys = '{32'h40000000, 32'h00000000, 32'hc0e00000};
      for (int i = 0; i < 3; i++) begin
         r = ref_div(xs[i], ys[i], 3'd3);
         run_op(xs[i], ys[i], 3'd3, z, fl, lat);
         n_total++;
         if (z !== r[31:0] || fl !== r[35:32] || lat !== (r[36] ? 2 : 29))
            $display("FAIL b2b_%0d: got %h/%b lat %0d required %h/%b", i, z, fl, lat, r[31:0], r[35:32]);
         else n_pass++;
      end
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.fp_X   = '0;
      bus.fp_Y   = '0;
      bus.r_mode = '0;
      test_reset();
      test_exact();
      test_one_third();
      test_specials();
      test_range();
      test_random();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
